// File: rtl/geo_temp_control_mz.sv
// Multi-zone geothermal temperature controller: per-zone IDLE/COOL/HEAT/LOCKOUT
// FSM with hysteresis, lockout timer, pump enable and shared threshold sanity check.
module geo_temp_control_mz #(
  parameter int unsigned W           = 8,
  parameter int unsigned N           = 4,
  parameter int unsigned HYST        = 5,
  parameter int unsigned LOCKOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     cooldown_th,
  input  logic [W-1:0]     heatup_th,
  input  logic [N*W-1:0]   zone_temp,
  input  logic [W-1:0]     ground_temp,
  input  logic             sample_valid,
  output logic [N-1:0]     pump_on,
  output logic [2*N-1:0]   mode,
  output logic             cfg_err
);

  localparam int unsigned   CW       = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LOCKOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOL    = 2'd1,
    HEAT    = 2'd2,
    LOCKOUT = 2'd3
  } zone_state_e;

  zone_state_e   state_q [N];
  zone_state_e   state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [W-1:0]  temp    [N];
  logic [N-1:0]  pump_q, pump_d;
  logic          cfg_err_q, cfg_err_d;
  logic [W:0]    hot_full, cold_full;
  logic [W-1:0]  hot_exit, cold_exit;

  // Exit thresholds computed one bit wider so the borrow/carry drives saturation.
  always_comb begin
    hot_full  = {1'b0, cooldown_th} - (W+1)'(HYST);
    cold_full = {1'b0, heatup_th} + (W+1)'(HYST);
    hot_exit  = hot_full[W]  ? '0 : hot_full[W-1:0];
    cold_exit = cold_full[W] ? '1 : cold_full[W-1:0];
    cfg_err_d = sample_valid ? (cold_exit >= hot_exit) : cfg_err_q;
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      temp[i] = zone_temp[i*W +: W];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pump_d[i]  = pump_q[i];
      if (cfg_err_d) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        pump_d[i]  = 1'b0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (sample_valid) begin
              if (temp[i] >= cooldown_th)     state_d[i] = COOL;
              else if (temp[i] <= heatup_th)  state_d[i] = HEAT;
            end
          end
          COOL: begin
            if (sample_valid && (temp[i] <= hot_exit)) begin
              state_d[i] = LOCKOUT;
              cnt_d[i]   = CNT_LOAD;
            end
          end
          HEAT: begin
            if (sample_valid && (temp[i] >= cold_exit)) begin
              state_d[i] = LOCKOUT;
              cnt_d[i]   = CNT_LOAD;
            end
          end
          LOCKOUT: begin
            if (cnt_q[i] == '0) state_d[i] = IDLE;
            else                cnt_d[i]   = cnt_q[i] - CW'(1);
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
        // Pump only runs in COOL/HEAT, so any other next state clears it.
        if (sample_valid) begin
          pump_d[i] = ((state_d[i] == COOL) && (ground_temp < temp[i]) && (temp[i] > hot_exit)) ||
                      ((state_d[i] == HEAT) && (ground_temp > temp[i]) && (temp[i] < cold_exit));
        end else if ((state_d[i] != COOL) && (state_d[i] != HEAT)) begin
          pump_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      pump_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pump_q    <= pump_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    mode = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mode[2*i +: 2] = state_q[i];
    end
    pump_on = pump_q;
    cfg_err = cfg_err_q;
  end

endmodule

// File: doc/geo_temp_control_mz.md
GEO_TEMP_CONTROL_MZ -- requirements
Module: geo_temp_control_mz

Interface
REQ-001 Parameter W, default 8, width of every temperature and threshold value (unsigned).
REQ-002 Parameter N, default 4, number of independently controlled zones.
REQ-003 Parameter HYST, default 5, hysteresis band in temperature units.
REQ-004 Parameter LOCKOUT_CYC, default 16, minimum number of clocks a zone stays in LOCKOUT after leaving COOL or HEAT (must be >= 1).
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 cooldown_th  input  W  upper threshold shared by all zones.
REQ-008 heatup_th  input  W  lower threshold shared by all zones.
REQ-009 zone_temp  input  N*W  zone i temperature in bits [i*W +: W].
REQ-010 ground_temp  input  W  geothermal loop temperature.
REQ-011 sample_valid  input  1  zone_temp/ground_temp/thresholds are valid this cycle.
REQ-012 pump_on  output  N  registered per-zone pump enable.
REQ-013 mode  output  2*N  registered per-zone state in bits [2i +: 2]: 0 IDLE, 1 COOL, 2 HEAT, 3 LOCKOUT.
REQ-014 cfg_err  output  1  registered flag: threshold configuration invalid.

Function
REQ-015 hot_exit = cooldown_th - HYST, saturating at 0; cold_exit = heatup_th + HYST, saturating at 2^W-1; both computed at W+1 bits before saturation.
REQ-016 Configuration is invalid when cold_exit >= hot_exit; evaluated only on cycles with sample_valid=1, cfg_err registered on that edge.
REQ-017 While cfg_err=1 (including the edge it is set), all zones go to IDLE, pump_on=0, lockout counters cleared; cfg_err clears on the next valid sample with valid configuration.
REQ-018 Zone FSM advances on sample_valid=1 only, except LOCKOUT countdown, which runs every clock.
REQ-019 IDLE: temp >= cooldown_th -> COOL; else temp <= heatup_th -> HEAT; else stay (cooldown test has priority).
REQ-020 COOL: temp <= hot_exit -> LOCKOUT; else stay.
REQ-021 HEAT: temp >= cold_exit -> LOCKOUT; else stay.
REQ-022 Entering LOCKOUT loads the zone counter with LOCKOUT_CYC-1; each subsequent clock decrements; the clock on which the counter is 0 moves the zone to IDLE; samples arriving during LOCKOUT are ignored for that zone.
REQ-023 A zone leaving LOCKOUT is re-evaluated only on the next sample_valid after it reaches IDLE; it never moves directly LOCKOUT->COOL/HEAT.
REQ-024 pump_on[i] updated on every sample_valid edge from the zone's next state and presented values: 1 if next=COOL and ground_temp < temp and temp > hot_exit, or next=HEAT and ground_temp > temp and temp < cold_exit; else 0.
REQ-025 pump_on[i] forced to 0 on the edge a zone enters LOCKOUT or IDLE, independent of sample_valid; holds its value otherwise.
REQ-026 Latency: input sample to mode/pump_on change is exactly one clock.
REQ-027 Zones are fully independent; simultaneous transitions in any combination of zones are legal.
REQ-028 Unused mode encodings are unreachable; if reached, zone returns to IDLE with pump_on=0 on the next clock.

Reset
REQ-029 On rst=1 at a rising edge: all mode=IDLE, pump_on=0, cfg_err=0, lockout counters=0, regardless of sample_valid; rst overrides all other behaviour.
REQ-030 Reset asserted mid-COOL/HEAT/LOCKOUT aborts the operation; no lockout is owed after reset.

Verification (N=4, W=8, HYST=5, LOCKOUT_CYC=4, cooldown_th=100, heatup_th=50)
REQ-031 Zone0 temp 100, ground 60, valid -> next clock mode0=COOL, pump_on[0]=1; temp 96 -> stays COOL; temp 95 -> LOCKOUT, pump_on[0]=0.
REQ-032 Zone1 temp 50, ground 70 -> HEAT, pump 1; temp 55 -> LOCKOUT; exactly 4 clocks later mode1=IDLE; valid sample of temp 100 during lockout ignored.
REQ-033 Zone2 temp 110, ground 120 (ground hotter) -> COOL with pump_on[2]=0; ground 90 on next sample -> pump_on[2]=1.
REQ-034 cooldown_th=60, heatup_th=55 with zones in COOL/HEAT -> next clock cfg_err=1, all modes IDLE, pump_on=0; restore 100/50 -> cfg_err=0 on next valid sample.
REQ-035 cooldown_th=3 (hot_exit saturates to 0), heatup_th=252 (cold_exit saturates to 255) -> cfg_err=1; no wrap-around observed.
REQ-036 rst pulsed one clock while zones 0-3 in COOL, HEAT, LOCKOUT, IDLE -> all IDLE, pump_on=0, cfg_err=0; next sample re-evaluates from IDLE.
